prng_ctrl: RTL and testbench



---
 rtl/prng_ctrl_pkg.sv | 15 +
 rtl/prng_ctrl_tick_div.sv | 35 +++
 rtl/prng_ctrl.sv | 179 +++++++++++++++++
 tb/tb_prng_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_ctrl_pkg.sv
// Shared definitions for the PRNG noise-source sequencer: state encoding and
// run-mode selectors.
package prng_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage : prng_ctrl_pkg

// File: rtl/prng_ctrl_tick_div.sv
// Programmable rate divider: o_tick fires once every (i_period + 1) enabled
// cycles, starting i_period cycles after the counter was last cleared.
module tick_div #(
  parameter int DIV_BITS = 8
) (
  input  logic                clk_in,
  input  logic                rst_in_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [DIV_BITS-1:0] i_period,
  output logic                o_tick
);

  logic [DIV_BITS-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_period);

  // Period counter: wraps to zero on tick, holds when disabled.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_cnt <= {DIV_BITS{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {DIV_BITS{1'b0}};
    end else if (i_en) begin
      if (o_tick) begin
        r_cnt <= {DIV_BITS{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(DIV_BITS-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule : tick_div

// File: rtl/prng_ctrl.sv
// Sequencer for the LFSR noise source: paces the PRNG advance enable, runs
// continuously or in triggered bursts, registers samples and counts epochs.
module prng_ctrl
  import prng_ctrl_pkg::*;
#(
  parameter int OUT_BITS   = 4,
  parameter int DIV_BITS   = 8,
  parameter int BURST_BITS = 16,
  parameter int EPOCH_BITS = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in_n,
  input  logic                  cfg_en_in,
  input  logic                  cfg_mode_in,
  input  logic [DIV_BITS-1:0]   cfg_div_in,
  input  logic [BURST_BITS-1:0] cfg_burst_len_in,
  input  logic                  start_in,
  input  logic                  prng_start_in,
  input  logic [OUT_BITS-1:0]   prng_data_in,
  output logic                  prng_ena_out,
  output logic [OUT_BITS-1:0]   noise_out,
  output logic                  noise_valid_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [EPOCH_BITS-1:0] epoch_cnt_out
);

  localparam logic [EPOCH_BITS-1:0] EPOCH_MAX = {EPOCH_BITS{1'b1}};

  state_e                r_state;
  state_e                w_next_state;
  logic [DIV_BITS-1:0]   r_div_lat;
  logic [BURST_BITS-1:0] r_len_lat;
  logic [BURST_BITS-1:0] r_burst_cnt;
  logic [BURST_BITS-1:0] w_burst_cnt_inc;
  logic [OUT_BITS-1:0]   r_noise;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [EPOCH_BITS-1:0] r_epoch;
  logic                  w_tick;
  logic                  w_running;
  logic                  w_len_zero;
  logic                  w_div_en;
  logic                  w_div_clr;
  logic                  w_entry;
  logic                  w_last_tick;

  assign w_running       = (r_state == ST_RUN) || (r_state == ST_BURST);
  assign w_len_zero      = (r_len_lat == {BURST_BITS{1'b0}});
  // A zero-length burst must never advance the PRNG, so its divider stays off.
  assign w_div_en        = (r_state == ST_RUN) || ((r_state == ST_BURST) && !w_len_zero);
  assign w_div_clr       = !w_running || (w_next_state != r_state);
  assign w_entry         = (r_state == ST_IDLE) && (w_next_state != ST_IDLE);
  assign w_burst_cnt_inc = r_burst_cnt + {{(BURST_BITS-1){1'b0}}, 1'b1};
  assign w_last_tick     = w_tick && (w_burst_cnt_inc == r_len_lat);

  tick_div #(
    .DIV_BITS (DIV_BITS)
  ) u_tick_div (
    .clk_in   (clk_in),
    .rst_in_n (rst_in_n),
    .i_clr    (w_div_clr),
    .i_en     (w_div_en),
    .i_period (r_div_lat),
    .o_tick   (w_tick)
  );

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_en_in && (cfg_mode_in == MODE_CONT)) begin
          w_next_state = ST_RUN;
        end else if (cfg_en_in && (cfg_mode_in == MODE_BURST) && start_in) begin
          w_next_state = ST_BURST;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!cfg_en_in) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_BURST: begin
        if (!cfg_en_in) begin
          w_next_state = ST_IDLE;
        end else if (w_len_zero || w_last_tick) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_BURST;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Configuration snapshot taken on entry, plus burst progress.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_div_lat   <= {DIV_BITS{1'b0}};
      r_len_lat   <= {BURST_BITS{1'b0}};
      r_burst_cnt <= {BURST_BITS{1'b0}};
    end else if (w_entry) begin
      r_div_lat   <= cfg_div_in;
      r_len_lat   <= cfg_burst_len_in;
      r_burst_cnt <= {BURST_BITS{1'b0}};
    end else if (w_tick && (r_state == ST_BURST)) begin
      r_burst_cnt <= w_burst_cnt_inc;
    end else begin
      r_burst_cnt <= r_burst_cnt;
    end
  end

  // Sample capture: the value present at the tick is the pre-advance sample.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_noise <= {OUT_BITS{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_tick;
      if (w_tick) begin
        r_noise <= prng_data_in;
      end else begin
        r_noise <= r_noise;
      end
    end
  end

  // Saturating count of PRNG sequence passes, restarted on every entry.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_epoch <= {EPOCH_BITS{1'b0}};
    end else if (w_entry) begin
      r_epoch <= {EPOCH_BITS{1'b0}};
    end else if (w_tick && prng_start_in && (r_epoch != EPOCH_MAX)) begin
      r_epoch <= r_epoch + {{(EPOCH_BITS-1){1'b0}}, 1'b1};
    end else begin
      r_epoch <= r_epoch;
    end
  end

  // Status flags registered from the next state so they align with it.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next_state == ST_RUN) || (w_next_state == ST_BURST);
      r_done <= (w_next_state == ST_DONE);
    end
  end

  assign prng_ena_out    = w_tick;
  assign noise_out       = r_noise;
  assign noise_valid_out = r_valid;
  assign busy_out        = r_busy;
  assign done_out        = r_done;
  assign epoch_cnt_out   = r_epoch;

endmodule : prng_ctrl

// File: tb/tb_prng_ctrl.sv
// Self-checking bench for prng_ctrl with a period-31 PRNG model and a sample
// scoreboard; a second instance with a 2-bit epoch counter checks saturation.
module tb_prng_ctrl;

  localparam int OB = 4;
  localparam int DB = 8;
  localparam int BB = 16;
  localparam int EB = 8;

  logic          clk_in = 1'b0;
  logic          rst_in_n = 1'b0;
  logic          cfg_en_in = 1'b0;
  logic          cfg_mode_in = 1'b0;
  logic [DB-1:0] cfg_div_in = '0;
  logic [BB-1:0] cfg_burst_len_in = '0;
  logic          start_in = 1'b0;
  logic          prng_start_in;
  logic [OB-1:0] prng_data_in;
  logic          prng_ena_out;
  logic [OB-1:0] noise_out;
  logic          noise_valid_out;
  logic          busy_out;
  logic          done_out;
  logic [EB-1:0] epoch_cnt_out;
  logic          s_ena2;
  logic [OB-1:0] s_noise2;
  logic          s_valid2;
  logic          s_busy2;
  logic          s_done2;
  logic [1:0]    s_epoch2;

  logic [4:0]    m_state;
  logic [OB-1:0] sb_q[$];
  logic [OB-1:0] last_noise;
  int checks = 0;
  int failures = 0;
  int n_ena = 0;
  int n_valid = 0;
  int n_done = 0;

  prng_ctrl #(.OUT_BITS(OB), .DIV_BITS(DB), .BURST_BITS(BB), .EPOCH_BITS(EB)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .cfg_en_in(cfg_en_in), .cfg_mode_in(cfg_mode_in),
    .cfg_div_in(cfg_div_in), .cfg_burst_len_in(cfg_burst_len_in), .start_in(start_in),
    .prng_start_in(prng_start_in), .prng_data_in(prng_data_in), .prng_ena_out(prng_ena_out),
    .noise_out(noise_out), .noise_valid_out(noise_valid_out), .busy_out(busy_out),
    .done_out(done_out), .epoch_cnt_out(epoch_cnt_out));

  prng_ctrl #(.OUT_BITS(OB), .DIV_BITS(DB), .BURST_BITS(BB), .EPOCH_BITS(2)) dut_sat (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .cfg_en_in(cfg_en_in), .cfg_mode_in(cfg_mode_in),
    .cfg_div_in(cfg_div_in), .cfg_burst_len_in(cfg_burst_len_in), .start_in(start_in),
    .prng_start_in(prng_start_in), .prng_data_in(prng_data_in), .prng_ena_out(s_ena2),
    .noise_out(s_noise2), .noise_valid_out(s_valid2), .busy_out(s_busy2),
    .done_out(s_done2), .epoch_cnt_out(s_epoch2));

  always #5 clk_in = ~clk_in;

  // PRNG stand-in: 31-state sequence, restarts on reset, start flag at state 0.
  always @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) m_state <= 5'd0;
    else if (prng_ena_out) m_state <= (m_state == 5'd30) ? 5'd0 : m_state + 5'd1;
  end
  assign prng_start_in = (m_state == 5'd0);
  assign prng_data_in  = {m_state[3:1], m_state[0] ^ m_state[4]};

  // Advance one clock and run the sample scoreboard.
  task automatic run_cycle();
    logic [OB-1:0] exp_v;
    @(posedge clk_in);
    #1;
    if (noise_valid_out) begin
      n_valid++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow noise_out=%h but no sample was expected", noise_out);
      end else begin
        exp_v = sb_q.pop_front();
        last_noise = exp_v;
        if (noise_out !== exp_v) begin
          failures++;
          $display("FAIL sb_noise got=%h expected=%h", noise_out, exp_v);
        end
      end
    end
    if (prng_ena_out) begin
      n_ena++;
      sb_q.push_back(prng_data_in);
    end
    if (done_out) n_done++;
  endtask

  task automatic test_reset();
    rst_in_n = 1'b0;
    #12;
    checks++;
    if ({prng_ena_out, noise_out, noise_valid_out, busy_out, done_out, epoch_cnt_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs ena=%b noise=%h valid=%b busy=%b done=%b epoch=%0d expected all 0",
               prng_ena_out, noise_out, noise_valid_out, busy_out, done_out, epoch_cnt_out);
    end
    @(negedge clk_in);
    rst_in_n = 1'b1;
    run_cycle();
    checks++;
    if ({prng_ena_out, busy_out} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset ena=%b busy=%b expected 0 0", prng_ena_out, busy_out);
    end
  endtask

  task automatic test_cont_div0();
    cfg_mode_in = 1'b0; cfg_div_in = 8'd0; cfg_en_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      checks++;
      if ({prng_ena_out, noise_valid_out, busy_out} !== {1'b1, (i >= 1), 1'b1}) begin
        failures++;
        $display("FAIL cont_div0 cyc=%0d ena/valid/busy=%b%b%b expected 1%0d1",
                 i, prng_ena_out, noise_valid_out, busy_out, (i >= 1));
      end
      if (i == 1) begin
        checks++;
        if (epoch_cnt_out !== 8'd1) begin
          failures++;
          $display("FAIL epoch_first_start got=%0d expected=1", epoch_cnt_out);
        end
      end
    end
    cfg_en_in = 1'b0;
    run_cycle();
    checks++;
    if ({prng_ena_out, noise_valid_out, busy_out} !== 3'b010) begin
      failures++;
      $display("FAIL cont_stop_tail ena/valid/busy=%b%b%b expected 010", prng_ena_out, noise_valid_out, busy_out);
    end
    run_cycle();
    run_cycle();
    checks++;
    if ({noise_valid_out, noise_out} !== {1'b0, last_noise}) begin
      failures++;
      $display("FAIL idle_hold valid=%b noise=%h expected valid=0 noise=%h", noise_valid_out, noise_out, last_noise);
    end
  endtask

  task automatic test_cont_div3();
    cfg_mode_in = 1'b0; cfg_div_in = 8'd3; cfg_en_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_cycle();
      checks++;
      if ({prng_ena_out, noise_valid_out} !== {(i % 4 == 3), (i % 4 == 0 && i > 0)}) begin
        failures++;
        $display("FAIL cont_div3 cyc=%0d ena/valid=%b%b expected %0d%0d",
                 i, prng_ena_out, noise_valid_out, (i % 4 == 3), (i % 4 == 0 && i > 0));
      end
    end
    cfg_en_in = 1'b0;
    run_cycle();
    run_cycle();
  endtask

  task automatic test_burst();
    logic [3:0] exp_f;
    n_ena = 0; n_done = 0;
    cfg_mode_in = 1'b1; cfg_div_in = 8'd1; cfg_burst_len_in = 16'd5; cfg_en_in = 1'b1; start_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_cycle();
      exp_f = {(i % 2 == 1 && i <= 9), (i % 2 == 0 && i >= 2 && i <= 10), (i <= 9), (i == 10)};
      checks++;
      if ({prng_ena_out, noise_valid_out, busy_out, done_out} !== exp_f) begin
        failures++;
        $display("FAIL burst cyc=%0d ena/valid/busy/done=%b%b%b%b expected %b",
                 i, prng_ena_out, noise_valid_out, busy_out, done_out, exp_f);
      end
      start_in = (i == 4);
    end
    checks++;
    if (n_ena != 5 || n_done != 1) begin
      failures++;
      $display("FAIL burst_counts ena=%0d done=%0d expected 5 1", n_ena, n_done);
    end
  endtask

  task automatic test_burst_len0();
    logic [3:0] exp_f;
    n_ena = 0; n_valid = 0;
    cfg_mode_in = 1'b1; cfg_div_in = 8'd0; cfg_burst_len_in = 16'd0; start_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      start_in = 1'b0;
      exp_f = {1'b0, 1'b0, (i == 0), (i == 1)};
      checks++;
      if ({prng_ena_out, noise_valid_out, busy_out, done_out} !== exp_f) begin
        failures++;
        $display("FAIL burst_len0 cyc=%0d ena/valid/busy/done=%b%b%b%b expected %b",
                 i, prng_ena_out, noise_valid_out, busy_out, done_out, exp_f);
      end
    end
    checks++;
    if (n_ena != 0 || n_valid != 0) begin
      failures++;
      $display("FAIL burst_len0_counts ena=%0d valid=%0d expected 0 0", n_ena, n_valid);
    end
  endtask

  task automatic test_epoch();
    rst_in_n = 1'b0;
    #3;
    sb_q.delete();
    @(negedge clk_in);
    rst_in_n = 1'b1;
    cfg_mode_in = 1'b0; cfg_div_in = 8'd0; cfg_en_in = 1'b1;
    for (int i = 0; i < 3 * 31 + 1; i++) run_cycle();
    cfg_en_in = 1'b0;
    run_cycle();
    checks++;
    if (epoch_cnt_out !== 8'd4) begin
      failures++;
      $display("FAIL epoch_count got=%0d expected=4", epoch_cnt_out);
    end
    checks++;
    if (s_epoch2 !== 2'd3) begin
      failures++;
      $display("FAIL epoch_saturate got=%0d expected=3", s_epoch2);
    end
    run_cycle();
  endtask

  task automatic test_abort();
    bit seen_done;
    n_ena = 0; n_done = 0;
    cfg_mode_in = 1'b1; cfg_div_in = 8'd1; cfg_burst_len_in = 16'd8; cfg_en_in = 1'b1; start_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      start_in = 1'b0;
      if (i == 0) begin
        checks++;
        if (epoch_cnt_out !== 8'd0) begin
          failures++;
          $display("FAIL epoch_clear_on_entry got=%0d expected=0", epoch_cnt_out);
        end
      end
    end
    cfg_en_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      checks++;
      if ({prng_ena_out, busy_out, done_out} !== 3'b000) begin
        failures++;
        $display("FAIL abort cyc=%0d ena/busy/done=%b%b%b expected 000", i, prng_ena_out, busy_out, done_out);
      end
    end
    checks++;
    if (n_ena != 2 || n_done != 0) begin
      failures++;
      $display("FAIL abort_counts ena=%0d done=%0d expected 2 0", n_ena, n_done);
    end
    n_ena = 0; n_done = 0; seen_done = 1'b0;
    cfg_en_in = 1'b1; start_in = 1'b1;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      run_cycle();
      start_in = 1'b0;
      seen_done = (n_done != 0);
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL rerun_timeout no done_out within 40 cycles");
    end
    checks++;
    if (n_ena != 8 || n_done != 1) begin
      failures++;
      $display("FAIL rerun_counts ena=%0d done=%0d expected 8 1", n_ena, n_done);
    end
    cfg_en_in = 1'b0;
    run_cycle();
  endtask

  task automatic test_mid_reset();
    cfg_mode_in = 1'b0; cfg_div_in = 8'd2; cfg_en_in = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle();
    rst_in_n = 1'b0;
    #2;
    checks++;
    if ({prng_ena_out, noise_out, noise_valid_out, busy_out, done_out, epoch_cnt_out, s_epoch2} !== '0) begin
      failures++;
      $display("FAIL mid_reset ena=%b noise=%h valid=%b busy=%b done=%b epoch=%0d expected all 0",
               prng_ena_out, noise_out, noise_valid_out, busy_out, done_out, epoch_cnt_out);
    end
    sb_q.delete();
    cfg_en_in = 1'b0;
    @(negedge clk_in);
    rst_in_n = 1'b1;
    run_cycle();
    run_cycle();
  endtask

  initial begin
    test_reset();
    test_cont_div0();
    test_cont_div3();
    test_burst();
    test_burst_len0();
    test_epoch();
    test_abort();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prng_ctrl
